// File: rtl/bagman_input_pkg.sv
// Shared constants and types for the Bagman control-input stage:
// core vector bit positions, MiSTer joystick bit positions, PS/2 scan codes, coin FSM states.
package bagman_input_pkg;

    localparam int JOY_U = 0;
    localparam int JOY_D = 1;
    localparam int JOY_L = 2;
    localparam int JOY_R = 3;
    localparam int JOY_F = 4;
    localparam int JOY_P = 5;
    localparam int JOY_C = 6;

    localparam int MJ_R    = 0;
    localparam int MJ_L    = 1;
    localparam int MJ_D    = 2;
    localparam int MJ_U    = 3;
    localparam int MJ_F1   = 4;
    localparam int MJ_F2   = 5;
    localparam int MJ_S1   = 6;
    localparam int MJ_S2   = 7;
    localparam int MJ_COIN = 8;

    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_P1_F1   = 8'h29;
    localparam logic [7:0] SC_P1_F2   = 8'h14;
    localparam logic [7:0] SC_START1A = 8'h05;
    localparam logic [7:0] SC_START1B = 8'h16;
    localparam logic [7:0] SC_START2A = 8'h06;
    localparam logic [7:0] SC_START2B = 8'h1E;
    localparam logic [7:0] SC_COIN_A  = 8'h2E;
    localparam logic [7:0] SC_COIN_B  = 8'h36;
    localparam logic [7:0] SC_P2_UP   = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT = 8'h23;
    localparam logic [7:0] SC_P2_RGHT = 8'h34;
    localparam logic [7:0] SC_P2_F1   = 8'h1C;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_state_t;

    typedef struct packed {
        logic p1_u;
        logic p1_d;
        logic p1_l;
        logic p1_r;
        logic p1_f1;
        logic p1_f2;
        logic start1;
        logic start2;
        logic coin;
        logic p2_u;
        logic p2_d;
        logic p2_l;
        logic p2_r;
        logic p2_f1;
    } key_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bagman_input_ctrl_if.sv
// Bundle of raw MiSTer inputs and the two player vectors handed to the Bagman core.
interface bagman_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        autofire;
    logic [6:0]  joy_pcfrldu;
    logic [6:0]  joy_pcfrldu_2;

    modport master (
        output ps2_key, joystick_0, joystick_1, autofire,
        input  joy_pcfrldu, joy_pcfrldu_2
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, autofire,
        output joy_pcfrldu, joy_pcfrldu_2
    );
endinterface

// File: rtl/bagman_input_ctrl_coin_pulser.sv
// Coin request shaper: one fixed-width pulse per request rising edge, followed by a
// mandatory low gap and a wait for the request to be released.
module bagman_coin_pulser
    import bagman_input_pkg::*;
#(
    parameter int COIN_PULSE_CYC = 1200000,
    parameter int COIN_GAP_CYC   = 1200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic coin_o
);

    localparam int CNT_W = $clog2(max2(max2(COIN_PULSE_CYC, COIN_GAP_CYC), 2));
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYC - 1);

    coin_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             coin_q;
    logic             req_q;

    // req_q resets high so a request still held through reset is not seen as a new edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            req_q <= req_i;
            case (state_q)
                IDLE: begin
                    if (req_i && !req_q) begin
                        state_q <= PULSE;
                        coin_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= GAP;
                        coin_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) state_q <= WAIT_REL;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                WAIT_REL: begin
                    if (!req_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_o = coin_q;

endmodule

// File: rtl/bagman_input_ctrl.sv
// Bagman control-input stage: PS/2 key decode, joystick merge, coin shaping, registered outputs.
// Optional autofire gating on fire1 is built only when AUTOFIRE_EN is defined.
module bagman_input_ctrl
    import bagman_input_pkg::*;
#(
    parameter int COIN_PULSE_CYC = 1200000,
    parameter int COIN_GAP_CYC   = 1200000,
    parameter int AUTOFIRE_DIV   = 600000
) (
    input logic                clk_sys,
    input logic                reset_n,
    bagman_input_ctrl_if.slave bus
);

    logic       prev_tog_q;
    logic       armed_q;
    key_state_t key_q, key_d;
    logic [6:0] p1_q, p1_d;
    logic [6:0] p2_q, p2_d;
    logic       coin;
    logic       coin_req;
    logic       af_gate;

    wire        key_evt = armed_q & (bus.ps2_key[10] != prev_tog_q);
    wire        pressed = bus.ps2_key[9];
    wire        ext     = bus.ps2_key[8];
    wire [7:0]  code    = bus.ps2_key[7:0];

    // Arrows accept both plain and E0-prefixed codes; everything else must be non-extended
    always_comb begin
        key_d = key_q;
        if (key_evt) begin
            case (code)
                SC_UP:    key_d.p1_u = pressed;
                SC_DOWN:  key_d.p1_d = pressed;
                SC_LEFT:  key_d.p1_l = pressed;
                SC_RIGHT: key_d.p1_r = pressed;
                default: ;
            endcase
            if (!ext) begin
                case (code)
                    SC_P1_F1:               key_d.p1_f1  = pressed;
                    SC_P1_F2:               key_d.p1_f2  = pressed;
                    SC_START1A, SC_START1B: key_d.start1 = pressed;
                    SC_START2A, SC_START2B: key_d.start2 = pressed;
                    SC_COIN_A, SC_COIN_B:   key_d.coin   = pressed;
                    SC_P2_UP:               key_d.p2_u   = pressed;
                    SC_P2_DOWN:             key_d.p2_d   = pressed;
                    SC_P2_LEFT:             key_d.p2_l   = pressed;
                    SC_P2_RGHT:             key_d.p2_r   = pressed;
                    SC_P2_F1:               key_d.p2_f1  = pressed;
                    default: ;
                endcase
            end
        end
    end

    assign coin_req = key_q.coin | bus.joystick_0[MJ_COIN] | bus.joystick_1[MJ_COIN];

    bagman_coin_pulser #(
        .COIN_PULSE_CYC (COIN_PULSE_CYC),
        .COIN_GAP_CYC   (COIN_GAP_CYC)
    ) u_coin (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .req_i  (coin_req),
        .coin_o (coin)
    );

`ifdef AUTOFIRE_EN
    localparam int AF_W = $clog2(max2(AUTOFIRE_DIV, 2));
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_DIV - 1);

    logic [AF_W-1:0] af_cnt_q;
    logic            af_phase_q;

    // Phase starts high so the very first press after reset fires at once
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q <= af_cnt_q + 1'b1;
        end
    end

    assign af_gate = bus.autofire ? af_phase_q : 1'b1;
`else
    localparam int unused_af_div = AUTOFIRE_DIV;
    logic unused_af;
    assign unused_af = bus.autofire;
    assign af_gate   = 1'b1;
`endif

    logic unused_joy_hi;
    assign unused_joy_hi = ^{bus.joystick_0[15:9], bus.joystick_1[15:9]};

    always_comb begin
        p1_d        = '0;
        p1_d[JOY_U] = key_q.p1_u | bus.joystick_0[MJ_U];
        p1_d[JOY_D] = key_q.p1_d | bus.joystick_0[MJ_D];
        p1_d[JOY_L] = key_q.p1_l | bus.joystick_0[MJ_L];
        p1_d[JOY_R] = key_q.p1_r | bus.joystick_0[MJ_R];
        p1_d[JOY_F] = (key_q.p1_f1 | bus.joystick_0[MJ_F1]) & af_gate;
        p1_d[JOY_P] = key_q.start1 | bus.joystick_0[MJ_S1] | bus.joystick_1[MJ_S1]
                    | key_q.p1_f2 | bus.joystick_0[MJ_F2];
        p1_d[JOY_C] = coin;

        p2_d        = '0;
        p2_d[JOY_U] = key_q.p2_u | bus.joystick_1[MJ_U];
        p2_d[JOY_D] = key_q.p2_d | bus.joystick_1[MJ_D];
        p2_d[JOY_L] = key_q.p2_l | bus.joystick_1[MJ_L];
        p2_d[JOY_R] = key_q.p2_r | bus.joystick_1[MJ_R];
        p2_d[JOY_F] = (key_q.p2_f1 | bus.joystick_1[MJ_F1]) & af_gate;
        p2_d[JOY_P] = key_q.start2 | bus.joystick_0[MJ_S2] | bus.joystick_1[MJ_S2]
                    | bus.joystick_1[MJ_F2];
    end

    // armed_q blocks decode on the first cycle out of reset, while prev_tog_q learns the toggle level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_tog_q <= 1'b0;
            armed_q    <= 1'b0;
            key_q      <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
        end else begin
            prev_tog_q <= bus.ps2_key[10];
            armed_q    <= 1'b1;
            key_q      <= key_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
        end
    end

    assign bus.joy_pcfrldu   = p1_q;
    assign bus.joy_pcfrldu_2 = p2_q;

endmodule

// File: tb/tb_bagman_input_ctrl.sv
// Directed self-checking bench for bagman_input_ctrl (small coin/autofire timing constants).
module tb_bagman_input_ctrl;

    logic clk;
    logic rst_n;
    logic tog;
    int   checks;
    int   failures;
    int   pulses;
    int   highs;

    bagman_input_ctrl_if bus ();

    bagman_input_ctrl #(
        .COIN_PULSE_CYC (8),
        .COIN_GAP_CYC   (4),
        .AUTOFIRE_DIV   (3)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_key(input logic p, input logic e, input logic [7:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, p, e, code};
        tick(2);
    endtask

    // Samples n cycles; counts rising edges and high cycles of the P1 coin bit
    task automatic coin_window(input int n, output int np, output int nh);
        logic prev;
        prev = bus.joy_pcfrldu[6];
        np = 0;
        nh = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.joy_pcfrldu[6]) nh++;
            if (bus.joy_pcfrldu[6] && !prev) np++;
            prev = bus.joy_pcfrldu[6];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tog = 1'b1;
        bus.ps2_key = 11'h475;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        bus.autofire = 1'b0;
        tick(3);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00 || bus.joy_pcfrldu_2 !== 7'h00) begin
            $display("FAIL reset_outputs got=%h/%h exp=00/00", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL reset_toggle_no_event got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
    endtask

    task automatic test_key_fire;
        tog = ~tog;
        bus.ps2_key = {tog, 1'b1, 9'h029};
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL fire_latency1 got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h10) begin
            $display("FAIL fire_press got=%h exp=10", bus.joy_pcfrldu);
            failures++;
        end
        tog = ~tog;
        bus.ps2_key = {tog, 1'b0, 9'h029};
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h10) begin
            $display("FAIL fire_release_latency1 got=%h exp=10", bus.joy_pcfrldu);
            failures++;
        end
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL fire_release got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
    endtask

    task automatic test_extended;
        send_key(1'b1, 1'b1, 8'h75);
        checks++;
        if (bus.joy_pcfrldu !== 7'h01) begin
            $display("FAIL ext_arrow_up got=%h exp=01", bus.joy_pcfrldu);
            failures++;
        end
        send_key(1'b1, 1'b1, 8'h29);
        checks++;
        if (bus.joy_pcfrldu !== 7'h01) begin
            $display("FAIL ext_space_ignored got=%h exp=01", bus.joy_pcfrldu);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h75);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL plain_arrow_release got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
        send_key(1'b1, 1'b0, 8'h1A);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00 || bus.joy_pcfrldu_2 !== 7'h00) begin
            $display("FAIL unlisted_code got=%h/%h exp=00/00", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
    endtask

    task automatic test_shared_keys;
        send_key(1'b1, 1'b0, 8'h05);
        checks++;
        if (bus.joy_pcfrldu !== 7'h20) begin
            $display("FAIL start1_press got=%h exp=20", bus.joy_pcfrldu);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h16);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL start1_alt_release got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
        send_key(1'b1, 1'b0, 8'h1E);
        checks++;
        if (bus.joy_pcfrldu_2 !== 7'h20 || bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL start2_press got=%h/%h exp=00/20", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h06);
        send_key(1'b1, 1'b0, 8'h2D);
        send_key(1'b1, 1'b0, 8'h1C);
        checks++;
        if (bus.joy_pcfrldu_2 !== 7'h11) begin
            $display("FAIL p2_up_fire got=%h exp=11", bus.joy_pcfrldu_2);
            failures++;
        end
        send_key(1'b1, 1'b0, 8'h2B);
        send_key(1'b1, 1'b0, 8'h23);
        send_key(1'b1, 1'b0, 8'h34);
        checks++;
        if (bus.joy_pcfrldu_2 !== 7'h1F || bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL p2_all_dirs got=%h/%h exp=00/1f", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h2D);
        send_key(1'b0, 1'b0, 8'h1C);
        send_key(1'b0, 1'b0, 8'h2B);
        send_key(1'b0, 1'b0, 8'h23);
        send_key(1'b0, 1'b0, 8'h34);
        send_key(1'b1, 1'b0, 8'h14);
        checks++;
        if (bus.joy_pcfrldu !== 7'h20 || bus.joy_pcfrldu_2 !== 7'h00) begin
            $display("FAIL p1_fire2 got=%h/%h exp=20/00", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h14);
    endtask

    task automatic test_joystick;
        bus.joystick_0 = 16'h0003;
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h0C) begin
            $display("FAIL joy0_right_left got=%h exp=0c", bus.joy_pcfrldu);
            failures++;
        end
        bus.joystick_1 = 16'h0040;
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h2C || bus.joy_pcfrldu_2 !== 7'h00) begin
            $display("FAIL joy1_start1_to_p1 got=%h/%h exp=2c/00", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        bus.joystick_0 = 16'h0080;
        bus.joystick_1 = 16'h0005;
        tick(1);
        checks++;
        if (bus.joy_pcfrldu !== 7'h00 || bus.joy_pcfrldu_2 !== 7'h2A) begin
            $display("FAIL joy_start2_p2_dirs got=%h/%h exp=00/2a", bus.joy_pcfrldu, bus.joy_pcfrldu_2);
            failures++;
        end
        bus.joystick_0 = 16'h0000;
        bus.joystick_1 = 16'h0030;
        tick(1);
        checks++;
        if (bus.joy_pcfrldu_2 !== 7'h30) begin
            $display("FAIL joy1_fire_fire2 got=%h exp=30", bus.joy_pcfrldu_2);
            failures++;
        end
        bus.joystick_1 = 16'h0000;
        tick(2);
    endtask

    task automatic test_coin_joystick;
        int p2;
        int h2;
        bus.joystick_0[8] = 1'b1;
        coin_window(40, pulses, highs);
        checks++;
        if (pulses != 1 || highs != 8) begin
            $display("FAIL coin_held_one_pulse got=%0d pulses %0d highs exp=1 pulses 8 highs", pulses, highs);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(5, pulses, highs);
        bus.joystick_0[8] = 1'b1;
        coin_window(3, pulses, highs);
        checks++;
        if (pulses != 1) begin
            $display("FAIL coin_repress_after_wait got=%0d exp=1", pulses);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(7, pulses, highs);
        bus.joystick_0[8] = 1'b1;
        coin_window(20, p2, h2);
        checks++;
        if (pulses + p2 != 0 || h2 != 0) begin
            $display("FAIL coin_gap_repress_ignored got=%0d pulses %0d highs exp=0 pulses 0 highs", pulses + p2, h2);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(3, pulses, highs);
        bus.joystick_0[8] = 1'b1;
        coin_window(15, pulses, highs);
        checks++;
        if (pulses != 1 || highs != 8) begin
            $display("FAIL coin_third_pulse got=%0d pulses %0d highs exp=1 pulses 8 highs", pulses, highs);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(5, pulses, highs);
    endtask

    task automatic test_coin_key;
        send_key(1'b1, 1'b0, 8'h2E);
        coin_window(20, pulses, highs);
        checks++;
        if (pulses != 1 || highs != 8) begin
            $display("FAIL coin_key_pulse got=%0d pulses %0d highs exp=1 pulses 8 highs", pulses, highs);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h36);
        coin_window(4, pulses, highs);
        send_key(1'b1, 1'b0, 8'h36);
        coin_window(20, pulses, highs);
        checks++;
        if (pulses != 1 || highs != 8) begin
            $display("FAIL coin_alt_key_pulse got=%0d pulses %0d highs exp=1 pulses 8 highs", pulses, highs);
            failures++;
        end
        send_key(1'b0, 1'b0, 8'h2E);
        coin_window(5, pulses, highs);
    endtask

    task automatic test_coin_reset;
        bus.joystick_0[8] = 1'b1;
        coin_window(4, pulses, highs);
        checks++;
        if (pulses != 1) begin
            $display("FAIL coin_reset_pre_pulse got=%0d exp=1", pulses);
            failures++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.joy_pcfrldu !== 7'h00) begin
            $display("FAIL coin_async_drop got=%h exp=00", bus.joy_pcfrldu);
            failures++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        coin_window(30, pulses, highs);
        checks++;
        if (pulses != 0 || highs != 0) begin
            $display("FAIL coin_held_through_reset got=%0d pulses %0d highs exp=0 pulses 0 highs", pulses, highs);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(3, pulses, highs);
        bus.joystick_0[8] = 1'b1;
        coin_window(12, pulses, highs);
        checks++;
        if (pulses != 1 || highs != 8) begin
            $display("FAIL coin_after_reset_repress got=%0d pulses %0d highs exp=1 pulses 8 highs", pulses, highs);
            failures++;
        end
        bus.joystick_0[8] = 1'b0;
        coin_window(15, pulses, highs);
    endtask

    task automatic test_autofire;
        logic exp;
        bus.joystick_1 = 16'h0010;
        bus.autofire = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
`ifdef AUTOFIRE_EN
            exp = ((i % 6) < 3);
`else
            exp = 1'b1;
`endif
            checks++;
            if (bus.joy_pcfrldu_2[4] !== exp) begin
                $display("FAIL autofire_on_sample%0d got=%b exp=%b", i, bus.joy_pcfrldu_2[4], exp);
                failures++;
            end
        end
        bus.autofire = 1'b0;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (bus.joy_pcfrldu_2[4] !== 1'b1) begin
                $display("FAIL autofire_off_sample%0d got=%b exp=1", i, bus.joy_pcfrldu_2[4]);
                failures++;
            end
        end
        bus.joystick_1 = 16'h0000;
        tick(2);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_key_fire();
        test_extended();
        test_shared_keys();
        test_joystick();
        test_coin_joystick();
        test_coin_key();
        test_coin_reset();
        test_autofire();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
